// File: rtl/braid_mix_scheduler.sv
// ---------------------------------------------------------------------------
// braid_mix_scheduler
//
// Sequences one "braid run" over a ROWS x COLS grid of mixers: opens every
// input valve for LOAD_CYCLES cycles, then visits each mixer in turn (row
// ROWS-1 down to 0, column 0 up to COLS-1 within each row). For each mixer it
// raises mix_req until the actuator acknowledges, then holds mix_active for
// MIX_CYCLES cycles. A one-cycle done pulse closes the run.
//
// Optional feature (macro BRAID_SCHED_ACK_TIMEOUT_EN): if no mix_ack arrives
// within ACK_TIMEOUT cycles of ISSUE, the run stops in ERR with a sticky err
// flag. Without the macro, ISSUE waits forever and err is tied to 0.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin one full braid run (honoured in IDLE and ERR)
//   abort      in   cancel the current run, back to IDLE
//   mix_ack    in   actuator accepted the current mix_req
//   load_valve out  [ROWS] input valve opens
//   mix_req    out  request to actuate mixer at mix_row/mix_col
//   mix_row    out  row of the targeted mixer
//   mix_col    out  column of the targeted mixer
//   mix_active out  mixer dwell in progress
//   mix_count  out  completed mixes in the current run
//   busy       out  run in progress (LOAD, ISSUE, MIX)
//   done       out  one-cycle pulse at run completion
//   err        out  sticky ack-timeout flag
// ---------------------------------------------------------------------------
module braid_mix_scheduler #(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int LOAD_CYCLES = 8,
    parameter int MIX_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 64,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW  = $clog2(ROWS * COLS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            mix_ack,
    output logic [ROWS-1:0] load_valve,
    output logic            mix_req,
    output logic [RW-1:0]   mix_row,
    output logic [CLW-1:0]  mix_col,
    output logic            mix_active,
    output logic [NW-1:0]   mix_count,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // One shared timer serves LOAD, MIX and the ISSUE ack watchdog, so it
    // must hold the largest of the three limits.
    localparam int TMAX_LM = (LOAD_CYCLES > MIX_CYCLES) ? LOAD_CYCLES : MIX_CYCLES;
    localparam int TMAX    = (TMAX_LM > ACK_TIMEOUT) ? TMAX_LM : ACK_TIMEOUT;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0]  LOAD_LAST = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0]  MIX_LAST  = TW'(MIX_CYCLES - 1);
    localparam logic [TW-1:0]  T_ONE     = TW'(1);
    localparam logic [RW-1:0]  ROW_FIRST = RW'(ROWS - 1);
    localparam logic [RW-1:0]  ROW_ONE   = RW'(1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);
    localparam logic [CLW-1:0] COL_ONE   = CLW'(1);
    localparam logic [NW-1:0]  CNT_ONE   = NW'(1);
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
    localparam logic [TW-1:0]  ACK_LAST  = TW'(ACK_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        MIX   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic [ROWS-1:0] load_valve_q, load_valve_d;
    logic            mix_req_q, mix_req_d;
    logic            mix_active_q, mix_active_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
        err_d   = err_q;
`endif

        if (abort) begin
            // Abort outranks every other event and leaves a clean IDLE.
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end
                end
                LOAD: begin
                    if (tmr_q == LOAD_LAST) begin
                        state_d = ISSUE;
                        row_d   = ROW_FIRST;
                        col_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + T_ONE;
                    end
                end
                ISSUE: begin
                    if (mix_ack) begin
                        state_d = MIX;
                        tmr_d   = '0;
                    end
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
                    else if (tmr_q == ACK_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + T_ONE;
                    end
`endif
                end
                MIX: begin
                    if (tmr_q == MIX_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                        tmr_d = '0;
                        // The last mixer leaves row/col in place so the final
                        // position stays visible until the next start.
                        if (row_q == '0 && col_q == COL_LAST) begin
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q - ROW_ONE;
                            end else begin
                                col_d = col_q + COL_ONE;
                            end
                        end
                    end else begin
                        tmr_d = tmr_q + T_ONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                ERR: begin
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
                    if (start) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they leave the flops
        // aligned with the state they describe.
        load_valve_d = (state_d == LOAD) ? {ROWS{1'b1}} : {ROWS{1'b0}};
        mix_req_d    = (state_d == ISSUE);
        mix_active_d = (state_d == MIX);
        busy_d       = (state_d == LOAD) || (state_d == ISSUE) || (state_d == MIX);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            load_valve_q <= '0;
            mix_req_q    <= 1'b0;
            mix_active_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            load_valve_q <= load_valve_d;
            mix_req_q    <= mix_req_d;
            mix_active_q <= mix_active_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign load_valve = load_valve_q;
    assign mix_req    = mix_req_q;
    assign mix_row    = row_q;
    assign mix_col    = col_q;
    assign mix_active = mix_active_q;
    assign mix_count  = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// ---------------------------------------------------------------------------
// tb_braid_mix_scheduler
//
// Randomized bench for braid_mix_scheduler at default parameters. The bench
// plays the actuator: for mixer k it withholds mix_ack for dly[k] cycles.
// Expected behaviour is derived from the run rules directly: mixer k sits at
// row ROWS-1-k/COLS, column k%COLS; each mix costs dly[k]+1 request cycles
// plus MIX_CYCLES dwell cycles; the load phase lasts LOAD_CYCLES cycles.
// Spurious start/mix_ack pulses are injected where they must be ignored.
// ---------------------------------------------------------------------------
module tb_braid_mix_scheduler;

    localparam int ROWS        = 4;
    localparam int COLS        = 8;
    localparam int LOAD_CYCLES = 8;
    localparam int MIX_CYCLES  = 16;
    localparam int ACK_TIMEOUT = 64;
    localparam int NMIX        = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst, start, abort, mix_ack;
    logic [ROWS-1:0] load_valve;
    logic            mix_req;
    logic [1:0]      mix_row;
    logic [2:0]      mix_col;
    logic            mix_active;
    logic [5:0]      mix_count;
    logic            busy, done, err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int dly [NMIX];

    always #5 clk = ~clk;

    braid_mix_scheduler #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .LOAD_CYCLES(LOAD_CYCLES),
        .MIX_CYCLES (MIX_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mix_ack   (mix_ack),
        .load_valve(load_valve),
        .mix_req   (mix_req),
        .mix_row   (mix_row),
        .mix_col   (mix_col),
        .mix_active(mix_active),
        .mix_count (mix_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valve"},  32'(load_valve), 0);
        check_val({tag, "_req"},    32'(mix_req),    0);
        check_val({tag, "_active"}, 32'(mix_active), 0);
        check_val({tag, "_busy"},   32'(busy),       0);
        check_val({tag, "_done"},   32'(done),       0);
        check_val({tag, "_err"},    32'(err),        0);
        check_val({tag, "_row"},    32'(mix_row),    0);
        check_val({tag, "_col"},    32'(mix_col),    0);
        check_val({tag, "_count"},  32'(mix_count),  0);
    endtask

    // Random start/ack pulses; only used while the DUT is in LOAD or MIX.
    task automatic noise(input bit en);
        if (en) begin
            start   = 1'($urandom_range(0, 1));
            mix_ack = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic kill(input bit use_rst, input string tag);
        if (use_rst) rst = 1'b1;
        else         abort = 1'b1;
        start   = 1'($urandom_range(0, 1));
        mix_ack = 1'($urandom_range(0, 1));
        step();
        rst = 1'b0; abort = 1'b0; start = 1'b0; mix_ack = 1'b0;
        check_all_zero(tag);
    endtask

    // One braid run. kill_mix >= 0 kills during the dwell of that mixer;
    // kill_in_load kills during LOAD; kill_rst selects rst over abort.
    task automatic run(input int kill_mix, input bit kill_rst, input bit kill_in_load,
                       input bit nz, input string tag);
        int nload, nreq, nact, bad, t_first, exp_span;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_cnt_clr"}, 32'(mix_count), 0);
        check_val({tag, "_busy_load"}, 32'(busy), 1);

        nload = 0;
        while (load_valve === 4'b1111 && nload < 200) begin
            if (kill_in_load && nload == 3) begin
                kill(kill_rst, {tag, "_kill_load"});
                return;
            end
            noise(nz);
            nload++;
            step();
            start = 1'b0; mix_ack = 1'b0;
        end
        check_val({tag, "_load_len"}, nload, LOAD_CYCLES);

        t_first  = cyc;
        exp_span = 0;
        for (int k = 0; k < NMIX; k++) begin
            check_val($sformatf("%s_req_%0d", tag, k), 32'(mix_req), 1);
            check_val($sformatf("%s_row_%0d", tag, k), 32'(mix_row), ROWS - 1 - k / COLS);
            check_val($sformatf("%s_col_%0d", tag, k), 32'(mix_col), k % COLS);
            nreq = 0;
            bad  = 0;
            while (mix_req === 1'b1 && nreq < 200) begin
                if (mix_row !== 2'(ROWS - 1 - k / COLS) || mix_col !== 3'(k % COLS)) bad++;
                mix_ack = (nreq == dly[k]);
                nreq++;
                step();
                mix_ack = 1'b0;
            end
            check_val($sformatf("%s_reqlen_%0d", tag, k), nreq, dly[k] + 1);
            check_val($sformatf("%s_stable_%0d", tag, k), bad, 0);

            nact = 0;
            bad  = 0;
            while (mix_active === 1'b1 && nact < 200) begin
                if (mix_req !== 1'b0) bad++;
                if (kill_mix == k && nact == 5) begin
                    check_val({tag, "_cnt_at_kill"}, 32'(mix_count), k);
                    kill(kill_rst, {tag, "_kill_mix"});
                    return;
                end
                noise(nz);
                nact++;
                step();
                start = 1'b0; mix_ack = 1'b0;
            end
            check_val($sformatf("%s_mixlen_%0d", tag, k), nact, MIX_CYCLES);
            check_val($sformatf("%s_noreq_%0d", tag, k), bad, 0);
            check_val($sformatf("%s_count_%0d", tag, k), 32'(mix_count), k + 1);
            exp_span += dly[k] + 1 + MIX_CYCLES;
        end

        check_val({tag, "_done"}, 32'(done), 1);
        check_val({tag, "_span"}, cyc - t_first, exp_span);
        check_val({tag, "_busy_done"}, 32'(busy), 0);
        step();
        check_val({tag, "_done_pulse"}, 32'(done), 0);
        check_val({tag, "_busy_idle"}, 32'(busy), 0);
        check_val({tag, "_final_count"}, 32'(mix_count), NMIX);
        check_val({tag, "_final_row"}, 32'(mix_row), 0);
        check_val({tag, "_final_col"}, 32'(mix_col), COLS - 1);
        step();
        check_val({tag, "_hold_count"}, 32'(mix_count), NMIX);
    endtask

    task automatic fill_dly(input int mode);
        for (int i = 0; i < NMIX; i++) begin
            if (mode == 0) dly[i] = 0;
            else           dly[i] = int'($urandom_range(0, 6));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int nreq;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mix_ack = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle");

        // Zero-wait actuator, clean inputs.
        fill_dly(0);
        run(-1, 1'b0, 1'b0, 1'b0, "basic");

        // Ack held back 5 cycles on row 2, col 3; noise on start/ack.
        fill_dly(0);
        dly[1 * COLS + 3] = 5;
        run(-1, 1'b0, 1'b0, 1'b1, "slowack");

        // Abort in the dwell when mix_count is 10, then a clean restart.
        fill_dly(1);
        run(10, 1'b0, 1'b0, 1'b1, "abort");
        step();
        check_all_zero("abort_idle");
        fill_dly(0);
        run(-1, 1'b0, 1'b0, 1'b0, "restart");

        // Reset during LOAD and during MIX.
        fill_dly(1);
        run(-1, 1'b1, 1'b1, 1'b1, "rstload");
        run(5, 1'b1, 1'b0, 1'b1, "rstmix");

        // Random actuator latency with noise.
        fill_dly(1);
        run(-1, 1'b0, 1'b0, 1'b1, "random");

        // Ack withheld in ISSUE.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < LOAD_CYCLES; i++) step();
        nreq = 0;
        while (mix_req === 1'b1 && nreq < 100) begin
            nreq++;
            step();
        end
`ifdef BRAID_SCHED_ACK_TIMEOUT_EN
        check_val("to_req_len", nreq, ACK_TIMEOUT);
        check_val("to_err", 32'(err), 1);
        check_val("to_busy", 32'(busy), 0);
        mix_ack = 1'b1;
        step();
        step();
        mix_ack = 1'b0;
        check_val("to_err_sticky", 32'(err), 1);
        check_val("to_req_off", 32'(mix_req), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("to_err_clr", 32'(err), 0);
        check_val("to_reload", 32'(load_valve), 32'hF);
        kill(1'b0, "to_abort");
`else
        check_val("wait_req_len", nreq, 100);
        check_val("wait_req_held", 32'(mix_req), 1);
        check_val("wait_err", 32'(err), 0);
        check_val("wait_busy", 32'(busy), 1);
        // Abort must beat a simultaneous ack.
        abort = 1'b1;
        mix_ack = 1'b1;
        step();
        abort = 1'b0;
        mix_ack = 1'b0;
        check_all_zero("abort_vs_ack");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/braid_mix_scheduler.md
BRAID_MIX_SCHEDULER -- requirements
Module: braid_mix_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 4: mixer rows in the braid.
REQ-002 SHALL have parameter COLS, default 8: mixer columns in the braid.
REQ-003 SHALL have parameter LOAD_CYCLES, default 8: input-valve open time.
REQ-004 SHALL have parameter MIX_CYCLES, default 16: dwell time per mix.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 64: cycles allowed for mix_ack.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  synchronous active-high reset.
REQ-009 SHALL have port start  input  1  begin one full braid run.
REQ-010 SHALL have port abort  input  1  cancel the current run.
REQ-011 SHALL have port mix_ack  input  1  actuator accepted the current mix_req.
REQ-012 SHALL have port load_valve  output  ROWS  input valve opens, one bit per input_i.
REQ-013 SHALL have port mix_req  output  1  request to actuate the mixer at mix_row/mix_col.
REQ-014 SHALL have port mix_row  output  clog2(ROWS)  row of the targeted mixer.
REQ-015 SHALL have port mix_col  output  clog2(COLS)  column of the targeted mixer.
REQ-016 SHALL have port mix_active  output  1  mixer dwell in progress.
REQ-017 SHALL have port mix_count  output  clog2(ROWS*COLS)+1  completed mixes in the current run.
REQ-018 SHALL have port busy  output  1  run in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-020 SHALL have port err  output  1  sticky ack-timeout flag.

Function
REQ-021 SHALL implement the states IDLE, LOAD, ISSUE, MIX, DONE and ERR.
REQ-022 IDLE: start=1 SHALL move to LOAD next cycle and clear mix_count; busy=1 in every state except IDLE, DONE and ERR.
REQ-023 LOAD: load_valve SHALL be all-ones for exactly LOAD_CYCLES cycles, then the FSM SHALL go to ISSUE with row=ROWS-1, col=0.
REQ-024 ISSUE: mix_req=1 with a stable row/col; mix_ack=1 sampled -> MIX next cycle, mix_req=0 from that cycle.
REQ-025 MIX: mix_active=1 for exactly MIX_CYCLES cycles, then mix_count+1.
REQ-026 After MIX, col SHALL advance; at col=COLS-1, col wraps to 0 and row decrements.
REQ-027 After the mix at row=0, col=COLS-1, the FSM SHALL go to DONE instead of ISSUE.
REQ-028 DONE: done=1 for one cycle, then IDLE; row, col and mix_count SHALL hold their final values until the next start.
REQ-029 start SHALL be ignored in LOAD, ISSUE, MIX and DONE.
REQ-030 abort SHALL return any state to IDLE next cycle, with load_valve, mix_req, mix_active and busy all 0.
REQ-031 abort SHALL take priority over mix_ack, start and timer expiry in the same cycle.
REQ-032 mix_ack SHALL be ignored outside ISSUE.
REQ-033 Latency: start at cycle T gives load_valve high at T+1..T+LOAD_CYCLES and the first mix_req at T+LOAD_CYCLES+1.
REQ-034 A full run with zero-wait ack SHALL last ROWS*COLS*(MIX_CYCLES+1) cycles from the first mix_req to the done pulse.

Reset
REQ-035 rst SHALL force IDLE with every output 0 and row, col, mix_count and the timers cleared, overriding all other inputs including mid-run.

Configuration
REQ-036 Macro BRAID_SCHED_ACK_TIMEOUT_EN defined: ISSUE SHALL count cycles without mix_ack.
REQ-037 With the macro, ACK_TIMEOUT cycles without ack in ISSUE SHALL go to ERR: err=1 (sticky), mix_req=0, busy=0.
REQ-038 With the macro, ERR SHALL be left only by start (-> LOAD, err cleared), abort (-> IDLE, err cleared) or rst.
REQ-039 Macro undefined: ISSUE SHALL wait indefinitely, ERR is unreachable and err is tied to 0.

Verification
REQ-040 Defaults, start pulse, mix_ack tied 1 -> load_valve=4'b1111 for 8 cycles; 32 mixes visited row 3..0, col 0..7; done pulse; mix_count=32.
REQ-041 Ack delayed 5 cycles on mix (row 2, col 3) -> mix_req held 5 cycles with row/col stable; run still completes with mix_count=32.
REQ-042 abort during MIX at mix_count=10 -> IDLE next cycle, all outputs 0; a later start restarts at row 3, col 0 with mix_count=0.
REQ-043 With macro, mix_ack withheld -> err=1 after 64 ISSUE cycles; start then clears err and enters LOAD.
REQ-044 rst asserted in LOAD and again in MIX -> IDLE with all outputs 0 on the next cycle; start pulses during busy produce no effect.
